// File: rtl/trace_collector.sv
// trace_collector: per-channel trace FIFOs drained round-robin into one channel-tagged stream.
// Optional capture timestamps are built when TRACE_TIMESTAMP_EN is defined.
module trace_collector #(
    parameter int NCH   = 4,
    parameter int TW    = 32,
    parameter int FD    = 4,
    parameter int TSw   = 16,
    parameter int DROPw = 8,
    parameter int CHw   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       trigger_in,
    input  logic [NCH*TW-1:0]    trace_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TW-1:0]        out_trace,
    output logic [CHw-1:0]       out_ch,
    output logic [TSw-1:0]       out_ts,
    input  logic                 clear,
    output logic [NCH*DROPw-1:0] drop_cnt,
    output logic [NCH-1:0]       overflow
);
    localparam int AW = $clog2(FD);
`ifdef TRACE_TIMESTAMP_EN
    localparam int EW = TW + TSw;
    logic [TSw-1:0] ts_cnt;
`else
    localparam int EW = TW;
`endif

    logic [EW-1:0]  mem [NCH][FD];
    logic [AW:0]    wr_ptr [NCH];
    logic [AW:0]    rd_ptr [NCH];
    logic [NCH-1:0] nonempty, full, push, pop, drop;
    logic [CHw-1:0] last_gnt, gnt_ch_p0;
    logic           gnt_vld_p0, load_p0;
    logic [EW-1:0]  gnt_entry_p0;

    function automatic logic [DROPw-1:0] sat_inc(input logic [DROPw-1:0] v);
        return (&v) ? v : v + DROPw'(1);
    endfunction

    // Extra pointer MSB separates full from empty when the index bits match.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            nonempty[i] = (wr_ptr[i] != rd_ptr[i]);
            full[i]     = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                          (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
        end
    end

    // Stage p0: round-robin grant, searching from last_gnt+1 with wrap.
    assign load_p0 = !out_valid || out_ready;

    always_comb begin
        logic [CHw-1:0] idx_ch;
        gnt_vld_p0 = 1'b0;
        gnt_ch_p0  = '0;
        idx_ch     = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx_ch = CHw'((int'(last_gnt) + k) % NCH);
            if (load_p0 && !gnt_vld_p0 && nonempty[idx_ch]) begin
                gnt_vld_p0 = 1'b1;
                gnt_ch_p0  = idx_ch;
            end
        end
    end

    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            pop[i]  = gnt_vld_p0 && (gnt_ch_p0 == CHw'(i));
            push[i] = trigger_in[i] && (!full[i] || pop[i]);
            drop[i] = trigger_in[i] && full[i] && !pop[i];
        end
    end

    assign gnt_entry_p0 = mem[gnt_ch_p0][rd_ptr[gnt_ch_p0][AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + (AW+1)'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (push[i]) begin
`ifdef TRACE_TIMESTAMP_EN
                mem[i][wr_ptr[i][AW-1:0]] <= {ts_cnt, trace_in[i*TW +: TW]};
`else
                mem[i][wr_ptr[i][AW-1:0]] <= trace_in[i*TW +: TW];
`endif
            end
        end
    end

    // Stage p1: output register; data holds while stalled or after retirement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_trace <= '0;
            out_ch    <= '0;
            last_gnt  <= CHw'(NCH - 1);
`ifdef TRACE_TIMESTAMP_EN
            out_ts    <= '0;
`endif
        end else if (load_p0) begin
            out_valid <= gnt_vld_p0;
            if (gnt_vld_p0) begin
                out_trace <= gnt_entry_p0[TW-1:0];
                out_ch    <= gnt_ch_p0;
                last_gnt  <= gnt_ch_p0;
`ifdef TRACE_TIMESTAMP_EN
                out_ts    <= gnt_entry_p0[EW-1:TW];
`endif
            end
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ts_cnt <= '0;
        else       ts_cnt <= ts_cnt + TSw'(1);
    end
`else
    assign out_ts = '0;
`endif

    // A drop on the clear edge survives the clear as a single count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
            overflow <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clear) begin
                    drop_cnt[i*DROPw +: DROPw] <= drop[i] ? DROPw'(1) : '0;
                    overflow[i]                <= drop[i];
                end else if (drop[i]) begin
                    drop_cnt[i*DROPw +: DROPw] <= sat_inc(drop_cnt[i*DROPw +: DROPw]);
                    overflow[i]                <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_trace_collector.sv
// Bench for trace_collector: queue-based reference model plus directed and randomized traffic.
module tb_trace_collector;
    localparam int NCH = 4, TW = 32, FD = 4, TSw = 16, DROPw = 8, CHw = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NCH-1:0]       trigger_in = '0;
    logic [NCH*TW-1:0]    trace_in = '0;
    logic                 out_ready = 1'b0;
    logic                 clear = 1'b0;
    logic                 out_valid;
    logic [TW-1:0]        out_trace;
    logic [CHw-1:0]       out_ch;
    logic [TSw-1:0]       out_ts;
    logic [NCH*DROPw-1:0] drop_cnt;
    logic [NCH-1:0]       overflow;

    trace_collector #(.NCH(NCH), .TW(TW), .FD(FD), .TSw(TSw), .DROPw(DROPw)) dut (
        .clk(clk), .reset(reset), .trigger_in(trigger_in), .trace_in(trace_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_trace(out_trace),
        .out_ch(out_ch), .out_ts(out_ts), .clear(clear), .drop_cnt(drop_cnt),
        .overflow(overflow)
    );

    // Second instance with a 2-bit drop counter for saturation.
    logic [3:0]   s_trig = '0;
    logic [127:0] s_trace = '0;
    logic         s_valid;
    logic [31:0]  s_out_trace;
    logic [1:0]   s_ch;
    logic [15:0]  s_ts;
    logic [7:0]   s_drop;
    logic [3:0]   s_ovf;

    trace_collector #(.NCH(4), .TW(32), .FD(4), .TSw(16), .DROPw(2)) dut_sat (
        .clk(clk), .reset(reset), .trigger_in(s_trig), .trace_in(s_trace),
        .out_valid(s_valid), .out_ready(1'b0), .out_trace(s_out_trace),
        .out_ch(s_ch), .out_ts(s_ts), .clear(1'b0), .drop_cnt(s_drop),
        .overflow(s_ovf)
    );

    typedef struct packed { logic [TW-1:0] tr; logic [TSw-1:0] ts; } ent_t;
    ent_t           q [NCH][$];
    logic           m_vld;
    logic [TW-1:0]  m_trace;
    int             m_ch, m_last;
    logic [TSw-1:0] m_ts, m_tsc;
    int             m_drop [NCH];
    bit [NCH-1:0]   m_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            q[i].delete();
            m_drop[i] = 0;
        end
        m_vld = 0; m_trace = '0; m_ch = 0; m_ts = '0; m_tsc = '0;
        m_last = NCH - 1; m_ovf = '0;
    endtask

    // One clock edge of the collector, computed from the queue view.
    task automatic model_step();
        bit   load;
        int   g, idx;
        bit   drp [NCH];
        ent_t e;
        load = !m_vld || out_ready;
        g = -1;
        if (load)
            for (int k = 1; k <= NCH; k++) begin
                idx = (m_last + k) % NCH;
                if (g < 0 && q[idx].size() > 0) g = idx;
            end
        for (int i = 0; i < NCH; i++)
            drp[i] = trigger_in[i] && (q[i].size() == FD) && (g != i);
        if (g >= 0) begin
            e = q[g].pop_front();
            m_vld = 1; m_trace = e.tr; m_ts = e.ts; m_ch = g; m_last = g;
        end else if (load) begin
            m_vld = 0;
        end
        for (int i = 0; i < NCH; i++)
            if (trigger_in[i] && !drp[i]) begin
                e.tr = trace_in[i*TW +: TW];
                e.ts = m_tsc;
                q[i].push_back(e);
            end
        for (int i = 0; i < NCH; i++) begin
            if (clear) begin
                m_drop[i] = drp[i] ? 1 : 0;
                m_ovf[i]  = drp[i];
            end else if (drp[i]) begin
                if (m_drop[i] < (1 << DROPw) - 1) m_drop[i]++;
                m_ovf[i] = 1'b1;
            end
        end
        m_tsc = m_tsc + 16'd1;
    endtask

    task automatic compare_all();
        check_eq("out_valid", 64'(out_valid), 64'(m_vld));
        check_eq("out_trace", 64'(out_trace), 64'(m_trace));
        check_eq("out_ch", 64'(out_ch), 64'(m_ch));
`ifdef TRACE_TIMESTAMP_EN
        check_eq("out_ts", 64'(out_ts), 64'(m_ts));
`else
        check_eq("out_ts_zero", 64'(out_ts), 64'd0);
`endif
        for (int i = 0; i < NCH; i++) begin
            check_eq($sformatf("drop_cnt[%0d]", i), 64'(drop_cnt[i*DROPw +: DROPw]), 64'(m_drop[i]));
            check_eq($sformatf("overflow[%0d]", i), 64'(overflow[i]), 64'(m_ovf[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        compare_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_ch;
        logic [TW-1:0] hold_tr;
        int hold_ch;
        logic [TSw-1:0] cap_ts;

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        compare_all();

        // Single trigger in cycle 3, expected out in cycle 5.
        out_ready = 1'b1;
        repeat (3) step();
        trigger_in = 4'b0001;
        trace_in[31:0] = 32'hA5A5_0001;
        step();
        trigger_in = '0;
        check_eq("lat_c4_valid", 64'(out_valid), 64'd0);
        step();
        check_eq("lat_c5_valid", 64'(out_valid), 64'd1);
        check_eq("lat_c5_ch", 64'(out_ch), 64'd0);
        check_eq("lat_c5_trace", 64'(out_trace), 64'hA5A5_0001);
`ifdef TRACE_TIMESTAMP_EN
        check_eq("lat_c5_ts", 64'(out_ts), 64'd3);
`endif
        repeat (3) step();

        // Simultaneous triggers from a fresh reset.
        do_reset();
        out_ready = 1'b1;
        trigger_in = 4'b1111;
        trace_in = {32'h13, 32'h12, 32'h11, 32'h10};
        step();
        trigger_in = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("simul_valid", 64'(out_valid), 64'd1);
            check_eq("simul_ch", 64'(out_ch), 64'(k));
            check_eq("simul_trace", 64'(out_trace), 64'(32'h10 + 32'(k)));
        end
        check_eq("simul_no_drops", 64'(drop_cnt), 64'd0);
        repeat (3) step();

        // Round-robin between channels 1 and 3 under continuous triggering.
        prev_ch = -1;
        trigger_in = 4'b1010;
        for (int c = 0; c < 24; c++) begin
            trace_in[1*TW +: TW] = $urandom();
            trace_in[3*TW +: TW] = $urandom();
            step();
            if (m_vld) begin
                if (prev_ch >= 0)
                    check_eq("rr_alternate", 64'(out_ch), (prev_ch == 1) ? 64'd3 : 64'd1);
                prev_ch = m_ch;
            end
        end
        check_eq("rr_drops_ch1", 64'(drop_cnt[1*DROPw +: DROPw] != 0), 64'd1);
        check_eq("rr_drops_ch3", 64'(drop_cnt[3*DROPw +: DROPw] != 0), 64'd1);
        trigger_in = '0;
        repeat (12) step();

        // Overflow: park a word in the output stage, then flood channel 2.
        out_ready = 1'b0;
        trigger_in = 4'b0001;
        trace_in[31:0] = 32'hCAFE_0000;
        step();
        trigger_in = '0;
        step();
        trigger_in = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            trace_in[2*TW +: TW] = 32'hB000_0000 + 32'(c);
            step();
        end
        trigger_in = '0;
        check_eq("ovf_drop2", 64'(drop_cnt[2*DROPw +: DROPw]), 64'd2);
        check_eq("ovf_flag2", 64'(overflow[2]), 64'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_eq("clr_drop2", 64'(drop_cnt[2*DROPw +: DROPw]), 64'd0);
        check_eq("clr_flag2", 64'(overflow[2]), 64'd0);

        // Backpressure: stalled output must hold for 10 cycles.
        hold_tr = m_trace;
        hold_ch = m_ch;
        for (int c = 0; c < 10; c++) begin
            trigger_in = ($urandom_range(0, 1) != 0) ? 4'b0010 : 4'b0000;
            trace_in[1*TW +: TW] = $urandom();
            step();
            check_eq("stall_trace", 64'(out_trace), 64'(hold_tr));
            check_eq("stall_ch", 64'(out_ch), 64'(hold_ch));
        end
        trigger_in = '0;

        // Asynchronous reset mid-cycle with entries still buffered.
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_async_valid", 64'(out_valid), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            check_eq("post_rst_idle", 64'(out_valid), 64'd0);
        end

        // Saturation on the 2-bit counter instance.
        cap_ts = m_tsc;
        for (int c = 1; c <= 10; c++) begin
            s_trig = 4'b0001;
            s_trace[31:0] = 32'h5A00_0000 + 32'(c - 1);
            step();
            if (c == 7) check_eq("sat_drop_2", 64'(s_drop[1:0]), 64'd2);
        end
        s_trig = '0;
        check_eq("sat_drop_3", 64'(s_drop[1:0]), 64'd3);
        check_eq("sat_other_drops", 64'(s_drop[7:2]), 64'd0);
        check_eq("sat_ovf", 64'(s_ovf), 64'd1);
        check_eq("sat_valid", 64'(s_valid), 64'd1);
        check_eq("sat_ch", 64'(s_ch), 64'd0);
        check_eq("sat_trace", 64'(s_out_trace), 64'h5A00_0000);
`ifdef TRACE_TIMESTAMP_EN
        check_eq("sat_ts", 64'(s_ts), 64'(cap_ts));
`else
        check_eq("sat_ts_zero", 64'(s_ts), 64'd0);
`endif

        // Randomized traffic: heavy then light backpressure, occasional clear.
        for (int c = 0; c < 400; c++) begin
            trigger_in = 4'($urandom_range(0, 15));
            trace_in   = {$urandom(), $urandom(), $urandom(), $urandom()};
            out_ready  = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clear      = ($urandom_range(0, 31) == 0);
            step();
        end
        trigger_in = '0;
        clear = 1'b0;
        out_ready = 1'b1;
        repeat (25) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
